// File: rtl/issue_pair_queue_pkg.sv
// Shared types for the dual-issue queue: the decoded-instruction slot and
// the architectural zero register used by the hazard checks.
package issue_pair_queue_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        uses_rs1;
      logic        uses_rs2;
      logic        reg_write;
      logic        is_mem;
      logic        is_ctrl;
   } issue_slot_t;

endpackage

// File: rtl/issue_pair_queue_pair_check.sv
// Intra-pair hazard checker: pair_ok is low when second cannot issue alongside head.
// Purely combinational, no state, no flow control.
module issue_pair_queue_pair_check
   import issue_pair_queue_pkg::*;
(
   input  issue_slot_t head_i,
   input  issue_slot_t second_i,
   output logic        pair_ok_o
);

   logic raw;
   logic waw;
   logic mem_conflict;
   logic unused_fields;

   assign raw = head_i.reg_write && (head_i.rd != REG_ZERO) &&
                ((second_i.uses_rs1 && (second_i.rs1 == head_i.rd)) ||
                 (second_i.uses_rs2 && (second_i.rs2 == head_i.rd)));

   assign waw = head_i.reg_write && second_i.reg_write &&
                (head_i.rd == second_i.rd) && (head_i.rd != REG_ZERO);

   // Only one data-memory port is shared by the two lanes.
   assign mem_conflict = head_i.is_mem && second_i.is_mem;

   assign pair_ok_o = !(raw || waw || mem_conflict || head_i.is_ctrl);

   assign unused_fields = ^{head_i.instr, head_i.pc, head_i.rs1, head_i.rs2,
                            head_i.uses_rs1, head_i.uses_rs2,
                            second_i.instr, second_i.pc, second_i.is_ctrl};

endmodule

// File: rtl/issue_pair_queue.sv
// Circular issue queue taking up to two decoded slots per cycle and presenting 0-2 to the lanes.
// Issue is combinational from registered state; in_ready needs two free entries; stall holds the head.
module issue_pair_queue
   import issue_pair_queue_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  in_valid,
   input  issue_slot_t in_slot0,
   input  issue_slot_t in_slot1,
   output logic        in_ready,
   input  logic        stall,
   input  logic        flush,
   output logic        iss_valid1,
   output logic        iss_valid2,
   output issue_slot_t iss_slot1,
   output issue_slot_t iss_slot2,
   output logic [31:0] pair_count,
   output logic [31:0] single_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W-1:0] head_p1, tail_p1;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] enq_amt, deq_amt;
   logic [31:0]      pair_count_q, pair_count_d;
   logic [31:0]      single_count_q, single_count_d;
   logic             wr0, wr1;
   logic             pair_ok;

   issue_slot_t mem_q [DEPTH];

   assign head_p1 = head_q + PTR_W'(1);
   assign tail_p1 = tail_q + PTR_W'(1);

   assign in_ready = (count_q <= READY_MAX);

   // Flush discards any same-cycle enqueue so the redirect starts from an empty queue.
   assign wr0     = in_ready && in_valid[0] && !flush;
   assign wr1     = wr0 && in_valid[1];
   assign enq_amt = CNT_W'(wr0) + CNT_W'(wr1);

   assign iss_slot1 = mem_q[head_q];
   assign iss_slot2 = mem_q[head_p1];

   issue_pair_queue_pair_check u_pair_check (
      .head_i    (iss_slot1),
      .second_i  (iss_slot2),
      .pair_ok_o (pair_ok)
   );

   assign iss_valid1 = (count_q != '0) && !stall && !flush;
   assign iss_valid2 = iss_valid1 && (count_q >= CNT_W'(2)) && pair_ok;
   assign deq_amt    = CNT_W'(iss_valid1) + CNT_W'(iss_valid2);

   always_comb begin
      head_d         = head_q + deq_amt[PTR_W-1:0];
      tail_d         = tail_q + enq_amt[PTR_W-1:0];
      count_d        = count_q + enq_amt - deq_amt;
      pair_count_d   = pair_count_q;
      single_count_d = single_count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
      if (iss_valid1 && iss_valid2) begin
         pair_count_d = pair_count_q + 32'd1;
      end else if (iss_valid1) begin
         single_count_d = single_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         pair_count_q   <= '0;
         single_count_q <= '0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         pair_count_q   <= pair_count_d;
         single_count_q <= single_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr0) begin
         mem_q[tail_q] <= in_slot0;
      end
      if (wr1) begin
         mem_q[tail_p1] <= in_slot1;
      end
   end

   assign pair_count   = pair_count_q;
   assign single_count = single_count_q;

endmodule

// File: tb/tb_issue_pair_queue.sv
// Directed bench for issue_pair_queue: pairing rules, fill/stall/wrap, flush and reset.
module tb_issue_pair_queue;
   import issue_pair_queue_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [1:0]  in_valid;
   issue_slot_t in_slot0, in_slot1;
   logic        in_ready;
   logic        stall, flush;
   logic        iss_valid1, iss_valid2;
   issue_slot_t iss_slot1, iss_slot2;
   logic [31:0] pair_count, single_count;

   int total = 0;
   int bad   = 0;

   issue_pair_queue #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_slot0     (in_slot0),
      .in_slot1     (in_slot1),
      .in_ready     (in_ready),
      .stall        (stall),
      .flush        (flush),
      .iss_valid1   (iss_valid1),
      .iss_valid2   (iss_valid2),
      .iss_slot1    (iss_slot1),
      .iss_slot2    (iss_slot2),
      .pair_count   (pair_count),
      .single_count (single_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic issue_slot_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic u1, input logic u2, input logic rw,
                                      input logic mem, input logic ctl);
      issue_slot_t s;
      s.instr     = pc ^ 32'h5A5A_0000;
      s.pc        = pc;
      s.rd        = rd;
      s.rs1       = rs1;
      s.rs2       = rs2;
      s.uses_rs1  = u1;
      s.uses_rs2  = u2;
      s.reg_write = rw;
      s.is_mem    = mem;
      s.is_ctrl   = ctl;
      return s;
   endfunction

   function automatic issue_slot_t alu(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
      return mk(pc, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic enq2(input issue_slot_t s0, input issue_slot_t s1);
      in_slot0 = s0;
      in_slot1 = s1;
      in_valid = 2'b11;
      tick();
      in_valid = 2'b00;
      #1;
   endtask

   task automatic enq1(input issue_slot_t s0);
      in_slot0 = s0;
      in_valid = 2'b01;
      tick();
      in_valid = 2'b00;
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 2'b00;
      in_slot0 = '0;
      in_slot1 = '0;
      stall    = 1'b0;
      flush    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("rst_v1", iss_valid1, 0);
      check("rst_v2", iss_valid2, 0);
      check("rst_ready", in_ready, 1);
      check("rst_pair", pair_count, 0);
      check("rst_single", single_count, 0);

      // Independent pair issues together, oldest in lane 1.
      enq2(alu(32'h100, 5'd1, 5'd3, 5'd4), alu(32'h104, 5'd2, 5'd5, 5'd6));
      check("t1_v1", iss_valid1, 1);
      check("t1_v2", iss_valid2, 1);
      check("t1_pc1", iss_slot1.pc, 32'h100);
      check("t1_pc2", iss_slot2.pc, 32'h104);
      tick();
      check("t1_pair", pair_count, 1);
      check("t1_single", single_count, 0);
      check("t1_empty", iss_valid1, 0);

      // RAW on x5 splits the pair.
      enq2(alu(32'h108, 5'd5, 5'd1, 5'd2), alu(32'h10c, 5'd6, 5'd5, 5'd3));
      check("raw_v1", iss_valid1, 1);
      check("raw_v2", iss_valid2, 0);
      check("raw_pc1", iss_slot1.pc, 32'h108);
      tick();
      check("raw_c2_v1", iss_valid1, 1);
      check("raw_c2_v2", iss_valid2, 0);
      check("raw_c2_pc1", iss_slot1.pc, 32'h10c);
      tick();
      check("raw_single", single_count, 2);
      check("raw_pair", pair_count, 1);

      // Two loads share one memory port.
      enq2(mk(32'h110, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0),
           mk(32'h114, 5'd8, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
      check("mem_v2", iss_valid2, 0);
      tick();
      check("mem_c2_pc1", iss_slot1.pc, 32'h114);
      tick();
      check("mem_single", single_count, 4);

      // Branch never pairs with its successor.
      enq2(mk(32'h118, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1),
           alu(32'h11c, 5'd9, 5'd3, 5'd4));
      check("ctl_v1", iss_valid1, 1);
      check("ctl_v2", iss_valid2, 0);
      tick();
      tick();
      check("ctl_single", single_count, 6);

      // Writes to x0 create no dependency.
      enq2(alu(32'h120, 5'd0, 5'd1, 5'd2), alu(32'h124, 5'd10, 5'd0, 5'd0));
      check("x0_v2", iss_valid2, 1);
      check("x0_pc2", iss_slot2.pc, 32'h124);
      tick();
      check("x0_pair", pair_count, 2);

      // WAW on x11 splits.
      enq2(alu(32'h128, 5'd11, 5'd1, 5'd2), alu(32'h12c, 5'd11, 5'd3, 5'd4));
      check("waw_v2", iss_valid2, 0);
      tick();
      tick();
      check("waw_single", single_count, 8);

      // Slot 1 alone enqueues nothing.
      in_slot0 = alu(32'h130, 5'd12, 5'd1, 5'd2);
      in_valid = 2'b10;
      tick();
      in_valid = 2'b00;
      #1;
      check("v10_v1", iss_valid1, 0);
      check("v10_ready", in_ready, 1);

      // Single enqueue moves the pointers off pair alignment.
      enq1(alu(32'h200, 5'd12, 5'd1, 5'd2));
      check("one_v1", iss_valid1, 1);
      check("one_v2", iss_valid2, 0);
      check("one_pc1", iss_slot1.pc, 32'h200);
      tick();
      check("one_single", single_count, 9);
      check("one_empty", iss_valid1, 0);

      // Fill under stall, then drain across the pointer wrap.
      stall = 1'b1;
      #1;
      enq2(alu(32'h2a0, 5'd13, 5'd1, 5'd2), alu(32'h2a4, 5'd14, 5'd1, 5'd2));
      check("fill1_ready", in_ready, 1);
      check("fill1_v1", iss_valid1, 0);
      enq2(alu(32'h2a8, 5'd15, 5'd1, 5'd2), alu(32'h2ac, 5'd16, 5'd1, 5'd2));
      check("fill2_ready", in_ready, 0);
      check("fill2_v1", iss_valid1, 0);
      check("fill2_pc1", iss_slot1.pc, 32'h2a0);
      enq2(alu(32'h2b0, 5'd17, 5'd1, 5'd2), alu(32'h2b4, 5'd18, 5'd1, 5'd2));
      check("full_ready", in_ready, 0);
      check("full_hold_pc1", iss_slot1.pc, 32'h2a0);
      stall = 1'b0;
      #1;
      check("drain1_v1", iss_valid1, 1);
      check("drain1_v2", iss_valid2, 1);
      check("drain1_pc1", iss_slot1.pc, 32'h2a0);
      check("drain1_pc2", iss_slot2.pc, 32'h2a4);
      tick();
      check("drain2_v2", iss_valid2, 1);
      check("drain2_pc1", iss_slot1.pc, 32'h2a8);
      check("drain2_pc2", iss_slot2.pc, 32'h2ac);
      tick();
      check("drain_empty", iss_valid1, 0);
      check("drain_ready", in_ready, 1);
      check("drain_pair", pair_count, 4);

      // Flush with three queued and a blocked pair on the inputs.
      stall = 1'b1;
      #1;
      enq2(alu(32'h300, 5'd20, 5'd1, 5'd2), alu(32'h304, 5'd21, 5'd1, 5'd2));
      enq1(alu(32'h308, 5'd22, 5'd1, 5'd2));
      check("fl3_ready", in_ready, 0);
      stall    = 1'b0;
      flush    = 1'b1;
      in_slot0 = alu(32'h310, 5'd23, 5'd1, 5'd2);
      in_slot1 = alu(32'h314, 5'd24, 5'd1, 5'd2);
      in_valid = 2'b11;
      #1;
      check("fl_same_v1", iss_valid1, 0);
      tick();
      flush    = 1'b0;
      in_valid = 2'b00;
      #1;
      check("fl_v1", iss_valid1, 0);
      check("fl_ready", in_ready, 1);
      check("fl_pair", pair_count, 4);
      check("fl_single", single_count, 9);

      // Flush discards an enqueue that would otherwise be accepted.
      flush    = 1'b1;
      in_slot0 = alu(32'h320, 5'd25, 5'd1, 5'd2);
      in_slot1 = alu(32'h324, 5'd26, 5'd1, 5'd2);
      in_valid = 2'b11;
      tick();
      flush    = 1'b0;
      in_valid = 2'b00;
      #1;
      check("fl_enq_v1", iss_valid1, 0);

      enq2(alu(32'h330, 5'd27, 5'd1, 5'd2), alu(32'h334, 5'd28, 5'd1, 5'd2));
      check("post_fl_v2", iss_valid2, 1);
      check("post_fl_pc1", iss_slot1.pc, 32'h330);
      tick();
      check("post_fl_pair", pair_count, 5);

      // Reset while two entries are queued.
      stall = 1'b1;
      #1;
      enq2(alu(32'h340, 5'd29, 5'd1, 5'd2), alu(32'h344, 5'd30, 5'd1, 5'd2));
      check("prerst_ready", in_ready, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      stall = 1'b0;
      #1;
      check("mrst_v1", iss_valid1, 0);
      check("mrst_ready", in_ready, 1);
      check("mrst_pair", pair_count, 0);
      check("mrst_single", single_count, 0);

      enq2(alu(32'h350, 5'd1, 5'd3, 5'd4), alu(32'h354, 5'd2, 5'd5, 5'd6));
      check("after_rst_pc1", iss_slot1.pc, 32'h350);
      check("after_rst_v2", iss_valid2, 1);
      tick();
      check("after_rst_pair", pair_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
